// File: rtl/input_conditioner_pkg.sv
// Shared constants for the push-button input conditioner.
//   BTN_START / BTN_INT / BTN_RST : bit positions of each button in the
//                                   3-bit raw, level and press vectors.
//   NUM_BTN                       : number of conditioned buttons.
//   DEFAULT_STABLE_COUNT          : default debounce window in fpgaclock cycles.
//   DEFAULT_CNT_W                 : default width of each debounce counter.
package input_conditioner_pkg;

  localparam int unsigned BTN_START = 0;
  localparam int unsigned BTN_INT   = 1;
  localparam int unsigned BTN_RST   = 2;
  localparam int unsigned NUM_BTN   = 3;

  localparam int unsigned DEFAULT_STABLE_COUNT = 1000000;
  localparam int unsigned DEFAULT_CNT_W        = 20;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One push-button channel: 2-FF synchronizer, debounce counter, debounced
// state and a one-cycle press pulse on each debounced 0->1 transition.
// Ports:
//   clk    in   clock (rising edge)
//   reset  in   synchronous active-high reset; clears every register
//   raw    in   asynchronous raw button
//   level  out  debounced state
//   press  out  high for the one cycle after level goes 0->1
module input_conditioner_debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  // Terminal count: the state flips on the STABLE_COUNT-th consecutive
  // differing cycle, so the counter never has to hold STABLE_COUNT itself.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // Stage p0/p1: metastability synchronizer, only sync_p1 is used below
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      // Debounce stage: any agreeing cycle restarts the window
      press   <= 1'b0;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
        press <= sync_p1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Push-button input conditioner feeding the run-control block. Each raw
// button is synchronized and debounced; debounced presses become one-cycle
// pulses, with reset taking priority over interrupt and interrupt over start.
// A held reset button also blocks interrupt and start presses.
// Ports:
//   fpgaclock        in   system clock (rising edge)
//   reset            in   synchronous active-high block reset
//   btn_start        in   raw start button, asynchronous
//   btn_interrupt    in   raw interrupt button, asynchronous
//   btn_reset        in   raw reset button, asynchronous
//   start_pulse      out  one-cycle start press after priority masking
//   interrupt_pulse  out  one-cycle interrupt press after priority masking
//   reset_pulse      out  one-cycle reset press
//   btn_level        out  debounced levels {reset, interrupt, start}
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_COUNT = DEFAULT_STABLE_COUNT,
  parameter int unsigned CNT_W        = DEFAULT_CNT_W
) (
  input  logic       fpgaclock,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_interrupt,
  input  logic       btn_reset,
  output logic       start_pulse,
  output logic       interrupt_pulse,
  output logic       reset_pulse,
  output logic [2:0] btn_level
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  logic               start_mask;
  logic               int_mask;
  logic               rst_mask;

  always_comb begin
    raw            = '0;
    raw[BTN_START] = btn_start;
    raw[BTN_INT]   = btn_interrupt;
    raw[BTN_RST]   = btn_reset;
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    input_conditioner_debounce_channel #(
      .STABLE_COUNT(STABLE_COUNT),
      .CNT_W       (CNT_W)
    ) u_debounce_channel (
      .clk  (fpgaclock),
      .reset(reset),
      .raw  (raw[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  // Priority masking: lower-priority presses coinciding with a higher one,
  // or arriving while reset is held down, are dropped rather than queued.
  always_comb begin
    rst_mask   = press[BTN_RST];
    int_mask   = press[BTN_INT] & ~press[BTN_RST] & ~level[BTN_RST];
    start_mask = press[BTN_START] & ~press[BTN_INT] & ~press[BTN_RST]
               & ~level[BTN_RST];
  end

  // Output stage: registered pulses, one cycle behind the debounced level
  always_ff @(posedge fpgaclock) begin
    if (reset) begin
      reset_pulse     <= 1'b0;
      interrupt_pulse <= 1'b0;
      start_pulse     <= 1'b0;
    end else begin
      reset_pulse     <= rst_mask;
      interrupt_pulse <= int_mask;
      start_pulse     <= start_mask;
    end
  end

  // Debounced states are already registers with the required timing
  always_comb begin
    btn_level = level;
  end

endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;

  localparam int SC = 8;

  logic       fpgaclock = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_interrupt = 1'b0;
  logic       btn_reset = 1'b0;
  logic       start_pulse;
  logic       interrupt_pulse;
  logic       reset_pulse;
  logic [2:0] btn_level;

  int vectors = 0;
  int miscompares = 0;

  input_conditioner #(.STABLE_COUNT(SC), .CNT_W(4)) dut (
    .fpgaclock      (fpgaclock),
    .reset          (reset),
    .btn_start      (btn_start),
    .btn_interrupt  (btn_interrupt),
    .btn_reset      (btn_reset),
    .start_pulse    (start_pulse),
    .interrupt_pulse(interrupt_pulse),
    .reset_pulse    (reset_pulse),
    .btn_level      (btn_level)
  );

  always #5 fpgaclock = ~fpgaclock;

  // Reference model, bit index 0=start 1=interrupt 2=reset.
  // A channel's level flips when its synchronized input has disagreed with
  // the level on each of the last SC edges, all of them after the most
  // recent reset or flip of that channel.
  int       edge_n = 0;
  int       last_evt [3];
  bit [2:0] dif [0:8191];
  bit [2:0] m_s1, m_s2, m_lvl, m_press;
  bit       m_rp, m_ip, m_sp;

  task automatic model_edge(input bit r, input bit [2:0] b);
    bit [2:0] np;
    bit       stable;
    edge_n++;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_press = '0;
      m_rp = 0; m_ip = 0; m_sp = 0;
      for (int c = 0; c < 3; c++) last_evt[c] = edge_n;
    end else begin
      m_rp = m_press[2];
      m_ip = m_press[1] & !m_press[2] & !m_lvl[2];
      m_sp = m_press[0] & !m_press[1] & !m_press[2] & !m_lvl[2];
      np = '0;
      for (int c = 0; c < 3; c++) begin
        dif[edge_n][c] = (m_s2[c] != m_lvl[c]);
        stable = (edge_n - last_evt[c] >= SC);
        for (int k = edge_n - SC + 1; k <= edge_n; k++)
          if (k >= 1 && !dif[k][c]) stable = 0;
        if (stable) begin
          np[c]       = !m_lvl[c];
          m_lvl[c]    = !m_lvl[c];
          last_evt[c] = edge_n;
        end
      end
      m_press = np;
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic tick(input bit r, input bit [2:0] b);
    reset = r;
    {btn_reset, btn_interrupt, btn_start} = b;
    @(posedge fpgaclock);
    model_edge(r, b);
    #1;
    chk("model", {btn_level, reset_pulse, interrupt_pulse, start_pulse},
        {m_lvl, m_rp, m_ip, m_sp});
  endtask

  task automatic do_reset();
    tick(1'b1, 3'b000);
    tick(1'b1, 3'b000);
  endtask

  function automatic logic [5:0] pulses();
    return {3'b000, reset_pulse, interrupt_pulse, start_pulse};
  endfunction

  initial begin
    bit [2:0] lv;
    int       dur [3];
    bit [2:0] rb;
    int       ip_count;

    // 1: reset held with all buttons high, then released while still held
    tick(1'b1, 3'b111);
    chk("t1_rst_a", {btn_level, reset_pulse, interrupt_pulse, start_pulse}, 6'd0);
    tick(1'b1, 3'b111);
    chk("t1_rst_b", {btn_level, reset_pulse, interrupt_pulse, start_pulse}, 6'd0);
    for (int e = 1; e <= 14; e++) begin
      tick(1'b0, 3'b111);
      chk("t1_lvl", {3'b000, btn_level}, (e >= 10) ? 6'd7 : 6'd0);
      chk("t1_pulse", pulses(), (e == 11) ? 6'b000100 : 6'd0);
    end

    // 2: clean start press and release
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      tick(1'b0, 3'b001);
      chk("t2_lvl", {5'd0, btn_level[0]}, (e >= 10) ? 6'd1 : 6'd0);
      chk("t2_pulse", pulses(), (e == 11) ? 6'b000001 : 6'd0);
    end
    for (int e = 1; e <= 14; e++) begin
      tick(1'b0, 3'b000);
      chk("t2_rel_lvl", {5'd0, btn_level[0]}, (e < 10) ? 6'd1 : 6'd0);
      chk("t2_rel_pulse", pulses(), 6'd0);
    end

    // 3: interrupt bouncing with period 6, then held
    do_reset();
    for (int e = 0; e < 30; e++) begin
      tick(1'b0, ((e / 3) % 2 == 0) ? 3'b010 : 3'b000);
      chk("t3_bounce", pulses(), 6'd0);
    end
    ip_count = 0;
    for (int e = 1; e <= 20; e++) begin
      tick(1'b0, 3'b010);
      if (interrupt_pulse) ip_count++;
      chk("t3_pulse", pulses(), (e == 11) ? 6'b000010 : 6'd0);
    end
    chk("t3_count", 6'(ip_count), 6'd1);

    // 4: start too short, then exactly long enough
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      tick(1'b0, (e <= 7) ? 3'b001 : 3'b000);
      chk("t4_short", {btn_level, reset_pulse, interrupt_pulse, start_pulse}, 6'd0);
    end
    for (int e = 1; e <= 14; e++) begin
      tick(1'b0, (e <= 8) ? 3'b001 : 3'b000);
      chk("t4_lvl", {5'd0, btn_level[0]}, (e >= 10) ? 6'd1 : 6'd0);
      chk("t4_pulse", pulses(), (e == 11) ? 6'b000001 : 6'd0);
    end
    for (int e = 0; e < 12; e++) tick(1'b0, 3'b000);

    // 5: simultaneous press, start during held reset, start after release
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      tick(1'b0, 3'b111);
      chk("t5_simul", pulses(), (e == 11) ? 6'b000100 : 6'd0);
    end
    for (int e = 0; e < 12; e++) tick(1'b0, 3'b100);
    for (int e = 1; e <= 20; e++) begin
      tick(1'b0, 3'b101);
      chk("t5_masked", pulses(), 6'd0);
    end
    for (int e = 0; e < 14; e++) tick(1'b0, 3'b000);
    for (int e = 1; e <= 14; e++) begin
      tick(1'b0, 3'b001);
      chk("t5_after", pulses(), (e == 11) ? 6'b000001 : 6'd0);
    end

    // 6: block reset mid-count while start is held
    do_reset();
    for (int e = 1; e <= 7; e++) tick(1'b0, 3'b001);
    tick(1'b1, 3'b001);
    chk("t6_rst", {btn_level, reset_pulse, interrupt_pulse, start_pulse}, 6'd0);
    for (int e = 1; e <= 14; e++) begin
      tick(1'b0, 3'b001);
      chk("t6_pulse", pulses(), (e == 11) ? 6'b000001 : 6'd0);
    end

    // 7: random bouncing segments with occasional block reset
    do_reset();
    lv = '0;
    for (int c = 0; c < 3; c++) dur[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < 3; c++) begin
        if (dur[c] == 0) begin
          lv[c]  = 1'($urandom_range(0, 1));
          dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30))
                                               : int'($urandom_range(1, 9));
        end
        dur[c]--;
      end
      rb = lv;
      tick(($urandom_range(0, 199) == 0), rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
